bsg_arb_data_mux_fifo: RTL and testbench



---
 rtl/bsg_arb_data_mux_fifo.sv | 92 +++++++++
 tb/tb_bsg_arb_data_mux_fifo.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bsg_arb_data_mux_fifo.sv
// bsg_arb_data_mux_fifo: takes the arbiter's grant, muxes the winner's data
// word into a 2-entry FIFO and presents it on a valid/ready output.
// ready_i only touches registered state, so it never reaches arb_yumi_o.
module bsg_arb_data_mux_fifo #(
    parameter int els_p       = 128,
    parameter int width_p     = 32,
    parameter int tag_width_p = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       arb_v_i,
    input  logic [tag_width_p-1:0]     arb_tag_i,
    input  logic [els_p-1:0]           arb_sel_one_hot_i,
    output logic                       arb_yumi_o,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           data_yumi_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [tag_width_p-1:0]     tag_o,
    input  logic                       ready_i
);

    typedef struct packed {
        logic [width_p-1:0]     data;
        logic [tag_width_p-1:0] tag;
    } entry_t;

    entry_t             mem_q [2];
    logic [1:0]         count_q, count_d;
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [width_p-1:0] mux_data;
    logic               enq, deq;

    // Grant is taken whenever there is room; a full FIFO refuses even if
    // the head is leaving this cycle, which keeps ready_i off this path.
    assign arb_yumi_o  = arb_v_i & (count_q != 2'd2) & ~reset_i;
    assign data_yumi_o = arb_sel_one_hot_i & {els_p{arb_yumi_o}};

    assign enq = arb_yumi_o;
    assign deq = v_o & ready_i;

    assign v_o    = (count_q != 2'd0);
    assign data_o = mem_q[rptr_q].data;
    assign tag_o  = mem_q[rptr_q].tag;

    // Data mux indexed by tag; a tag with no matching requester yields 0.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < els_p; k++) begin
            if (arb_tag_i == tag_width_p'(k))
                mux_data = data_i[k*width_p +: width_p];
        end
    end

    // Next-state for occupancy and the two 1-bit pointers.
    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (enq && !deq)
            count_d = count_q + 2'd1;
        else if (deq && !enq)
            count_d = count_q - 2'd1;
        if (enq) wptr_d = ~wptr_q;
        if (deq) rptr_d = ~rptr_q;
    end

    // State registers and entry storage; reset drops all stored entries.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= 2'd0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            if (enq)
                mem_q[wptr_q] <= '{data: mux_data, tag: arb_tag_i};
        end
    end

    // The arbiter's one-hot select must agree with its tag.
    always_ff @(posedge clk_i) begin
        if (!reset_i && arb_v_i)
            assert (arb_sel_one_hot_i == (els_p'(1) << arb_tag_i));
    end

endmodule

// File: tb/tb_bsg_arb_data_mux_fifo.sv
// Directed + random bench for bsg_arb_data_mux_fifo against a queue model.
module tb_bsg_arb_data_mux_fifo;

    localparam int ELS = 128;
    localparam int W   = 32;
    localparam int TW  = 7;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              arb_v_i = 1'b0;
    logic [TW-1:0]     arb_tag_i = '0;
    logic [ELS-1:0]    arb_sel_one_hot_i = '0;
    logic              arb_yumi_o;
    logic [ELS*W-1:0]  data_i = '0;
    logic [ELS-1:0]    data_yumi_o;
    logic              v_o;
    logic [W-1:0]      data_o;
    logic [TW-1:0]     tag_o;
    logic              ready_i = 1'b0;

    int total = 0;
    int bad   = 0;
    bit known = 0;
    bit pin_en = 0;
    logic [W-1:0] pin_word = '0;

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
    } ent_t;
    ent_t q[$];

    bsg_arb_data_mux_fifo #(.els_p(ELS), .width_p(W)) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .arb_v_i           (arb_v_i),
        .arb_tag_i         (arb_tag_i),
        .arb_sel_one_hot_i (arb_sel_one_hot_i),
        .arb_yumi_o        (arb_yumi_o),
        .data_i            (data_i),
        .data_yumi_o       (data_yumi_o),
        .v_o               (v_o),
        .data_o            (data_o),
        .tag_o             (tag_o),
        .ready_i           (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [ELS-1:0] got, input logic [ELS-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
            $error("check %s", name);
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance the model at
    // the rising edge, return at the next negedge.
    task automatic cycle(input bit rst, input bit v, input int tag, input bit rdy);
        bit           yexp;
        bit           deq;
        logic [W-1:0] wexp;
        reset_i   = rst;
        arb_v_i   = v;
        arb_tag_i = TW'(tag);
        ready_i   = rdy;
        for (int k = 0; k < ELS; k++) data_i[k*W +: W] = $urandom;
        if (pin_en) data_i[tag*W +: W] = pin_word;
        arb_sel_one_hot_i = v ? (ELS'(1) << tag) : ELS'($urandom);
        #1;
        yexp = v && (q.size() < 2) && !rst;
        chk("arb_yumi", ELS'(arb_yumi_o), ELS'(yexp));
        chk("data_yumi", data_yumi_o, yexp ? arb_sel_one_hot_i : '0);
        if (known) begin
            chk("v_o", ELS'(v_o), ELS'(q.size() != 0));
            if (q.size() != 0) begin
                chk("data_o", ELS'(data_o), ELS'(q[0].d));
                chk("tag_o", ELS'(tag_o), ELS'(q[0].t));
            end
        end
        wexp = data_i[tag*W +: W];
        deq  = (q.size() != 0) && rdy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            known = 1;
        end else begin
            if (deq) void'(q.pop_front());
            if (yexp) q.push_back('{wexp, TW'(tag)});
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // reset held two cycles with a request present
        cycle(1, 1, 5, 1);
        cycle(1, 1, 5, 1);
        chk("rst_v", ELS'(v_o), '0);
        chk("rst_data", ELS'(data_o), '0);
        chk("rst_tag", ELS'(tag_o), '0);
        cycle(0, 0, 0, 1);

        // single grant, tag 37
        pin_en = 1; pin_word = 32'hDEADBEEF;
        cycle(0, 1, 37, 1);
        pin_en = 0;
        chk("single_v", ELS'(v_o), ELS'(1));
        chk("single_data", ELS'(data_o), ELS'(32'hDEADBEEF));
        chk("single_tag", ELS'(tag_o), ELS'(37));
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // back-pressure fills the FIFO, then full+dequeue, then resume
        cycle(0, 1, 1, 0);
        cycle(0, 1, 2, 0);
        cycle(0, 1, 3, 0);
        cycle(0, 1, 3, 1);
        cycle(0, 1, 3, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // streaming: 256 grants, tags 0..127 twice
        for (int i = 0; i < 256; i++) cycle(0, 1, i % 128, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 50) == 0, ($urandom % 4) != 0,
                  int'($urandom % 128), ($urandom % 3) != 0);

        // reset while holding two entries
        cycle(0, 1, 9, 0);
        cycle(0, 1, 10, 0);
        cycle(0, 1, 11, 0);
        cycle(1, 1, 12, 1);
        chk("midrst_v", ELS'(v_o), '0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 20, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
